// File: rtl/io_input_buffer.sv
// Input peripheral: synchronizes and debounces 10 slide switches and 4 push buttons,
// keeps a sticky press register, and serves LSU reads of the input-peripheral region.
module io_input_buffer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [9:0]  i_sw,
    input  logic [3:0]  i_button,
    input  logic        i_rd_en,
    input  logic [11:0] i_addr,
    output logic [31:0] o_rdata,
    output logic [9:0]  o_sw_db,
    output logic [3:0]  o_btn_db
);

    localparam int unsigned NBITS = 14;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [11:0] ADDR_SW    = 12'h000;
    localparam logic [11:0] ADDR_BTN   = 12'h010;
    localparam logic [11:0] ADDR_PRESS = 12'h014;

    logic [9:0]       sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic [3:0]       btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
    logic [NBITS-1:0] sync_bits;
    logic [NBITS-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [NBITS];
    logic [CNT_W-1:0] cnt_d [NBITS];
    logic [3:0]       sticky_q, sticky_d;
    logic [3:0]       press_rise;
    logic             rd_clear;

    always_comb begin
        sw_meta_d  = i_sw;
        sw_sync_d  = sw_meta_q;
        btn_meta_d = i_button;
        btn_sync_d = btn_meta_q;
    end

    // Buttons are active-low on the pins; flip to pressed=1 after the synchronizer.
    assign sync_bits = {~btn_sync_q, sw_sync_q};

    always_comb begin
        for (int i = 0; i < NBITS; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            if (sync_bits[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync_bits[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // A press landing on the same edge as the clearing read must survive.
    always_comb begin
        press_rise = stable_d[13:10] & ~stable_q[13:10];
        rd_clear   = i_rd_en && (i_addr == ADDR_PRESS);
        sticky_d   = (rd_clear ? 4'h0 : sticky_q) | press_rise;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '1;
            btn_sync_q <= '1;
            stable_q   <= '0;
            sticky_q   <= '0;
            for (int i = 0; i < NBITS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            stable_q   <= stable_d;
            sticky_q   <= sticky_d;
            for (int i = 0; i < NBITS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign o_sw_db  = stable_q[9:0];
    assign o_btn_db = stable_q[13:10];

    always_comb begin
        o_rdata = 32'h0;
        if (i_rd_en) begin
            case (i_addr)
                ADDR_SW:    o_rdata = {22'h0, o_sw_db};
                ADDR_BTN:   o_rdata = {28'h0, o_btn_db};
                ADDR_PRESS: o_rdata = {28'h0, sticky_q};
                default:    o_rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_input_buffer.sv
// Directed bench for io_input_buffer with DEBOUNCE_CYCLES=4 (acceptance after 6 edges).
module tb_io_input_buffer;

    logic        clk;
    logic        rst_n;
    logic [9:0]  sw;
    logic [3:0]  button;
    logic        rd_en;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic [9:0]  sw_db;
    logic [3:0]  btn_db;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        rd_en;
        logic [11:0] addr;
        logic [31:0] exp_rdata;
    } rd_vec_t;

    rd_vec_t rd_vecs [12];

    io_input_buffer #(.DEBOUNCE_CYCLES(4)) dut (
        .i_clk    (clk),
        .i_reset  (rst_n),
        .i_sw     (sw),
        .i_button (button),
        .i_rd_en  (rd_en),
        .i_addr   (addr),
        .o_rdata  (rdata),
        .o_sw_db  (sw_db),
        .o_btn_db (btn_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic read_now(input logic [11:0] a, input logic [31:0] exp, input string name);
        rd_en = 1'b1;
        addr  = a;
        #1;
        check(name, rdata, exp);
    endtask

    initial begin
        rd_vecs[0]  = '{1'b0, 12'h000, 32'h0000_0000};
        rd_vecs[1]  = '{1'b0, 12'h014, 32'h0000_0000};
        rd_vecs[2]  = '{1'b1, 12'h000, 32'h0000_02A5};
        rd_vecs[3]  = '{1'b1, 12'h010, 32'h0000_0006};
        rd_vecs[4]  = '{1'b1, 12'h014, 32'h0000_0002};
        rd_vecs[5]  = '{1'b1, 12'h004, 32'h0000_0000};
        rd_vecs[6]  = '{1'b1, 12'h008, 32'h0000_0000};
        rd_vecs[7]  = '{1'b1, 12'h00C, 32'h0000_0000};
        rd_vecs[8]  = '{1'b1, 12'h018, 32'h0000_0000};
        rd_vecs[9]  = '{1'b1, 12'h114, 32'h0000_0000};
        rd_vecs[10] = '{1'b1, 12'h800, 32'h0000_0000};
        rd_vecs[11] = '{1'b1, 12'hFFF, 32'h0000_0000};

        rst_n  = 1'b0;
        sw     = 10'h000;
        button = 4'hF;
        rd_en  = 1'b0;
        addr   = 12'h000;
        repeat (3) tick();

        // Reset state; a level present at release must still take the full latency.
        sw = 10'h2A5;
        tick();
        check("reset_sw_db", {22'h0, sw_db}, 32'h0);
        check("reset_btn_db", {28'h0, btn_db}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("sw_latency_edge%0d", e), {22'h0, sw_db}, 32'h0);
        end
        tick();
        check("sw_latency_edge6", {22'h0, sw_db}, 32'h0000_02A5);
        read_now(12'h000, 32'h0000_02A5, "read_sw");
        rd_en = 1'b0;

        // Three-cycle bounce on button 1 must be rejected.
        button = 4'b1101;
        repeat (3) tick();
        button = 4'hF;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("bounce_btn_db_%0d", e), {28'h0, btn_db}, 32'h0);
        end
        read_now(12'h014, 32'h0, "bounce_sticky");
        tick();
        rd_en = 1'b0;

        // Button 2 held: acceptance, sticky read-clear, level read.
        button = 4'b1011;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("btn2_edge%0d", e), {28'h0, btn_db}, 32'h0);
        end
        tick();
        check("btn2_edge6", {28'h0, btn_db}, 32'h4);
        read_now(12'h014, 32'h4, "sticky_first_read");
        tick();
        check("sticky_second_read", rdata, 32'h0);
        rd_en = 1'b0;
        tick();
        read_now(12'h010, 32'h4, "read_btn_level");
        rd_en = 1'b0;

        // Button 1 pressed too: levels 0x6, sticky 0x2, then the decode table.
        button = 4'b1001;
        repeat (6) tick();
        check("btn1_accept", {28'h0, btn_db}, 32'h6);
        for (int i = 0; i < 12; i++) begin
            rd_en = rd_vecs[i].rd_en;
            addr  = rd_vecs[i].addr;
            #1;
            check($sformatf("rd_vec%0d_addr%03h", i, rd_vecs[i].addr), rdata, rd_vecs[i].exp_rdata);
        end
        rd_en = 1'b0;
        addr  = 12'h000;

        // Non-clearing accesses across real edges leave sticky alone.
        rd_en = 1'b1; addr = 12'h004; tick();
        rd_en = 1'b1; addr = 12'h000; tick();
        rd_en = 1'b1; addr = 12'h010; tick();
        rd_en = 1'b0; addr = 12'h014; tick();
        read_now(12'h014, 32'h2, "sticky_unchanged");
        rd_en = 1'b0;

        // Clearing read on the same edge button 0 becomes stable: set wins.
        button = 4'b1000;
        repeat (5) tick();
        read_now(12'h014, 32'h2, "set_vs_clear_rdata");
        check("set_vs_clear_pre_btn", {28'h0, btn_db}, 32'h6);
        tick();
        check("set_vs_clear_btn_db", {28'h0, btn_db}, 32'h7);
        check("set_vs_clear_sticky", rdata, 32'h1);
        rd_en = 1'b0;

        // Reset in the middle of a switch debounce.
        sw = 10'h0F0;
        repeat (4) tick();
        check("midcount_sw_db_held", {22'h0, sw_db}, 32'h0000_02A5);
        rst_n = 1'b0;
        #1;
        check("midcount_reset_sw_db", {22'h0, sw_db}, 32'h0);
        check("midcount_reset_btn_db", {28'h0, btn_db}, 32'h0);
        check("midcount_reset_rdata", rdata, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("post_reset_sw_edge%0d", e), {22'h0, sw_db}, 32'h0);
        end
        tick();
        check("post_reset_sw_edge6", {22'h0, sw_db}, 32'h0000_00F0);
        check("post_reset_btn_edge6", {28'h0, btn_db}, 32'h7);
        read_now(12'h014, 32'h7, "post_reset_sticky");
        rd_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/io_input_buffer.md
IO_INPUT_BUFFER -- requirements
Module: io_input_buffer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the consecutive synchronized cycles an input must hold a new level before acceptance (legal range 2..65535).
REQ-002 SHALL have port i_clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_sw  input  10  raw slide switches, active-high, asynchronous to i_clk.
REQ-005 SHALL have port i_button  input  4  raw push buttons, active-low (0 = pressed), asynchronous to i_clk.
REQ-006 SHALL have port i_rd_en  input  1  LSU read strobe for the input-peripheral region.
REQ-007 SHALL have port i_addr  input  12  byte offset within the input-peripheral region.
REQ-008 SHALL have port o_rdata  output  32  read data to the LSU.
REQ-009 SHALL have port o_sw_db  output  10  debounced switch levels.
REQ-010 SHALL have port o_btn_db  output  4  debounced button levels, active-high (1 = pressed).

Function
REQ-011 SHALL pass each raw bit through a 2-flop synchronizer; button bits inverted after synchronization.
REQ-012 SHALL keep per bit (14 total) a stable register and a debounce counter sized to hold DEBOUNCE_CYCLES-1.
REQ-013 SHALL, per bit per cycle: sync == stable -> counter := 0; sync != stable and counter < DEBOUNCE_CYCLES-1 -> counter += 1; sync != stable and counter == DEBOUNCE_CYCLES-1 -> stable := sync, counter := 0.
REQ-014 SHALL make a raw change held steady visible on o_sw_db/o_btn_db exactly DEBOUNCE_CYCLES+2 rising edges after it is first sampled.
REQ-015 SHALL reject any pulse/glitch shorter than DEBOUNCE_CYCLES synchronized cycles; one cycle of sync == stable restarts the count from 0.
REQ-016 SHALL keep a 4-bit sticky press register; bit n set on the edge where stable button n goes 0->1.
REQ-017 SHALL clear the whole sticky register on the edge where i_rd_en=1 and i_addr=0x014; a press event on that same edge sets its bit (set wins over clear).
REQ-018 SHALL drive o_rdata combinationally: i_rd_en=0 -> 0x0000_0000; offset 0x000 -> {22'b0, o_sw_db}; 0x010 -> {28'b0, o_btn_db}; 0x014 -> {28'b0, sticky} (pre-clear value); any other offset -> 0x0000_0000.
REQ-019 SHALL have no side effect for reads of offsets 0x000, 0x010 or unmapped offsets.
REQ-020 SHALL drive o_sw_db and o_btn_db directly from the stable registers (no added latency).

Reset
REQ-021 SHALL, on i_reset=0, asynchronously force switch sync flops to 0, button sync flops to raw-released (1), all counters to 0, all stable bits to 0, sticky to 0.
REQ-022 SHALL hold outputs at o_sw_db=0, o_btn_db=0, o_rdata=0 (with i_rd_en=0) during reset.
REQ-023 SHALL discard any debounce in progress when reset asserts mid-count; after release counting restarts from 0.
REQ-024 SHALL treat a raw level present at reset release as a new change, subject to full REQ-014 latency.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 SHALL cover: reset release, i_sw=0x2A5 held steady -> o_sw_db 0x000 through edge 5, 0x2A5 after edge 6; read 0x000 -> 0x0000_02A5.
REQ-026 SHALL cover: i_button[1]=0 for 3 cycles then 1 (bounce) -> o_btn_db stays 0x0, sticky stays 0x0.
REQ-027 SHALL cover: i_button[2] held 0 -> o_btn_db=0x4 after 6 edges; read 0x014 -> 0x0000_0004; next read 0x014 -> 0x0000_0000; read 0x010 -> 0x0000_0004.
REQ-028 SHALL cover: read 0x014 on the same edge button 0 becomes stable pressed while sticky=0x2 -> o_rdata=0x0000_0002, sticky afterwards 0x1.
REQ-029 SHALL cover: i_reset pulsed low at count 2 of a switch change -> o_sw_db=0 immediately; after release change needs full 6 edges.
REQ-030 SHALL cover: read of unmapped 0x004 and any read with i_rd_en=0 -> o_rdata=0x0000_0000, sticky unchanged.
